// File: rtl/mu0_pkg.sv
// mu0_pkg
// Definitions shared by the MU0 control path: the sequencer and the instruction decoder.
//   state_t        : sequencer state encoding (HALT, FETCH, EXEC1, EXEC2)
//   OP_*           : opcode constants, as seen in IR[15:12]
//   is_illegal_op  : true for the reserved opcode range 4'b1100-4'b1111
package mu0_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC1 = 2'd2,
    ST_EXEC2 = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // The reserved range is exactly the set of opcodes whose top two bits are both set.
  function automatic logic is_illegal_op(input logic [3:0] opcode);
    return (opcode[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/mu0_flag_reg.sv
// mu0_flag_reg
// Derives the EQ/MI/GE condition flags from the accumulator and registers them on
// every clock edge, whatever state the sequencer is in.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset; the flags reset as for a zero accumulator
//   acc    in   accumulator contents
//   eq     out  registered (acc == 0)
//   mi     out  registered sign bit of acc
//   ge     out  registered inverse of the sign bit of acc
module mu0_flag_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] acc,
  output logic              eq,
  output logic              mi,
  output logic              ge
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq <= 1'b1;
      mi <= 1'b0;
      ge <= 1'b1;
    end else begin
      eq <= (acc == '0);
      mi <= acc[DATA_W-1];
      ge <= ~acc[DATA_W-1];
    end
  end

endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer
// MU0 control-state sequencer. It steps HALT -> FETCH -> EXEC1 [-> EXEC2] and drives
// one-hot phase outputs to the instruction decoder. It also handles STP halt,
// run/single-step control, a sticky illegal-opcode flag and saturating counters.
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   run               start/resume; only looked at in HALT
//   step              1 = return to HALT after every retired instruction
//   clr_count         synchronous clear of both counters and illegal_op
//   op                IR opcode, valid during EXEC1/EXEC2
//   EXTRA             decoder request for an EXEC2 phase, valid during EXEC1
//   acc               accumulator, used for the condition flags
//   FETCH/EXEC1/EXEC2 registered one-hot phase outputs, all 0 in HALT
//   EQ/MI/GE          registered condition flags
//   halted            1 while in HALT
//   illegal_op        sticky, set when an opcode in 1100-1111 reaches EXEC1
//   instr_count       retired instructions, saturating
//   cycle_count       cycles spent outside HALT, saturating
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              clr_count,
  input  logic [3:0]        op,
  input  logic              EXTRA,
  input  logic [DATA_W-1:0] acc,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              EQ,
  output logic              MI,
  output logic              GE,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_next;
  logic   retire;

  // An instruction retires when it leaves EXEC1 without asking for EXEC2, or when it
  // leaves EXEC2. STP takes the first path, so it is counted like any other instruction.
  assign retire = ((state == ST_EXEC1) && !EXTRA) || (state == ST_EXEC2);

  always_comb begin
    state_next = state;
    unique case (state)
      ST_HALT:  state_next = run ? ST_FETCH : ST_HALT;
      ST_FETCH: state_next = ST_EXEC1;
      ST_EXEC1: begin
        // EXTRA takes priority: a multi-phase instruction always gets to finish.
        if (EXTRA)             state_next = ST_EXEC2;
        else if (op == OP_STP) state_next = ST_HALT;
        else if (step)         state_next = ST_HALT;
        else                   state_next = ST_FETCH;
      end
      ST_EXEC2: state_next = step ? ST_HALT : ST_FETCH;
      default:  state_next = ST_HALT;
    endcase
  end

  // The phase outputs are registered from the next state. This keeps them one-hot
  // and free of any combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_HALT;
      FETCH  <= 1'b0;
      EXEC1  <= 1'b0;
      EXEC2  <= 1'b0;
      halted <= 1'b1;
    end else begin
      state  <= state_next;
      FETCH  <= (state_next == ST_FETCH);
      EXEC1  <= (state_next == ST_EXEC1);
      EXEC2  <= (state_next == ST_EXEC2);
      halted <= (state_next == ST_HALT);
    end
  end

  // Counters and the sticky illegal flag. clr_count beats any increment or set on
  // the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      cycle_count <= '0;
      illegal_op  <= 1'b0;
    end else if (clr_count) begin
      instr_count <= '0;
      cycle_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      if (retire && (instr_count != CNT_MAX))
        instr_count <= instr_count + 1'b1;
      if ((state != ST_HALT) && (cycle_count != CNT_MAX))
        cycle_count <= cycle_count + 1'b1;
      if ((state == ST_EXEC1) && is_illegal_op(op))
        illegal_op <= 1'b1;
    end
  end

  mu0_flag_reg #(
    .DATA_W(DATA_W)
  ) u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (acc),
    .eq    (EQ),
    .mi    (MI),
    .ge    (GE)
  );

endmodule
